egg_timer_ctrl: RTL and testbench
=================================

# egg_timer_ctrl

Countdown controller for the egg timer. It holds the MM:SS count in BCD and sequences set, run, pause and alarm from debounced button pulses. It generates the one-second time base with an internal prescaler. It drives the eight 4-bit digit inputs of the display driver plus alarm and status outputs, so it sits between the button debouncers and the seven-segment display driver.

## Interface
- TICK_DIV, 100000000: clk cycles per one-second tick; minimum 2; benches use 4.
- ALARM_SECS, 10: ticks spent in ALARM before auto-return to IDLE; minimum 1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btnStart  in  1  single-cycle pulse, start/stop toggle.
- btnClear  in  1  single-cycle pulse, abort and zero the count.
- btnMin  in  1  single-cycle pulse, +1 minute (IDLE only).
- btnSec  in  1  single-cycle pulse, +1 second (IDLE only).
- v0  out  4  seconds ones (BCD).
- v1  out  4  seconds tens (BCD, 0..5).
- v2  out  4  minutes ones (BCD).
- v3  out  4  minutes tens (BCD).
- v4  out  4  state code: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM.
- v5, v6, v7  out  4 each  constant 0.
- alarm  out  1  high while in ALARM.
- running  out  1  high while in RUN.

## Operation
- States are IDLE, RUN, PAUSE and ALARM. Inputs use this priority: btnClear, then btnStart, then btnMin/btnSec.
- IDLE:
  - btnMin: minutes +1 in BCD, 99 wraps to 00.
  - btnSec: seconds +1, 59 wraps to 00 with no carry into minutes.
  - btnMin and btnSec together: both apply.
  - btnStart with count ≠ 00:00: go to RUN and clear the prescaler.
  - btnStart with count = 00:00: ignored.
  - btnClear: count becomes 00:00.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps. The cycle where it equals TICK_DIV-1 is a tick.
  - Each tick decrements the count by one second. Seconds 00 borrows: seconds become 59 and minutes drop by 1.
  - If a decrement yields 00:00, go to ALARM on that same edge and clear the prescaler.
  - btnStart: go to PAUSE. The prescaler holds its value.
  - btnClear: go to IDLE with count 00:00.
  - btnMin and btnSec are ignored.
  - When btnStart lands on a tick cycle, the tick decrement applies first, then the move to PAUSE. If that decrement reaches 00:00, go to ALARM instead.
- PAUSE:
  - The count and prescaler are frozen.
  - btnStart: return to RUN, and the prescaler resumes from its held value.
  - btnClear: go to IDLE with count 00:00.
  - btnMin and btnSec are ignored.
- ALARM:
  - The count stays 00:00 and alarm = 1.
  - btnStart or btnClear: go to IDLE.
  - Otherwise, after ALARM_SECS ticks go to IDLE automatically. The tick counter is cleared on entry.
  - btnMin and btnSec are ignored.
- The count is never out of BCD range: each digit is 0..9 and seconds tens is 0..5.

## Timing
- Reset values, applied immediately and asynchronously:
  - state IDLE; count 00:00; prescaler 0; alarm tick counter 0.
  - v0..v7 = 0, alarm = 0, running = 0.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.
- A button pulse sampled at edge N shows its effect on outputs after edge N.
- From btnStart in IDLE, the first decrement is visible TICK_DIV cycles after entering RUN.
- In RUN, one decrement happens per TICK_DIV cycles, with exactly one tick per prescaler wrap.
- ALARM lasts ALARM_SECS × TICK_DIV cycles when no button is pressed.
- When rst is asserted mid-RUN or mid-ALARM, all outputs return to their reset values with no further tick.

## Test plan
All scenarios use TICK_DIV = 4 and ALARM_SECS = 2.
- Reset, then btnSec ×3 and btnMin ×1: v3..v0 = 0,1,0,3 and v4 = 0.
- From 00:00 in IDLE, btnStart: state stays IDLE with v4 = 0 and running = 0.
- Load 01:00, then btnStart: running = 1. After 4 cycles the count reads 00:59. After a further 59×4 cycles it reads 00:00 with v4 = 3 and alarm = 1. After 8 more cycles, v4 = 0 and alarm = 0.
- Load 00:05, start, wait 6 cycles, then btnStart: v4 = 2 with the count frozen at 00:04 for 20 cycles. btnStart again: the next decrement arrives 2 cycles later, because the prescaler resumes from its held value.
- btnMin ×100 in IDLE gives 00:00, since minutes wrap from 99. btnSec ×60 also gives 00:00, since seconds wrap with minutes unchanged. btnClear and btnStart pulsed together in RUN: result is IDLE with count 00:00.
- Assert rst asynchronously mid-RUN at count 00:03, between clock edges: all outputs go to 0 at once. After release, state is IDLE.

Source files
------------

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: BCD MM:SS countdown with set/run/pause/alarm sequencing and
// an internal one-second prescaler, feeding an eight-digit display driver.
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnStart,
    input  logic       btnClear,
    input  logic       btnMin,
    input  logic       btnSec,
    output logic [3:0] v0,
    output logic [3:0] v1,
    output logic [3:0] v2,
    output logic [3:0] v3,
    output logic [3:0] v4,
    output logic [3:0] v5,
    output logic [3:0] v6,
    output logic [3:0] v7,
    output logic       alarm,
    output logic       running
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    logic [1:0]    state, state_n;
    logic [3:0]    s0, s1, m0, m1, s0_n, s1_n, m0_n, m1_n;
    logic [PW-1:0] presc, presc_n;
    logic [AW-1:0] acnt, acnt_n;
    logic          tick, borrow_m, nonzero, last_sec;
    logic [3:0]    dec_s0, dec_s1, dec_m0, dec_m1;
    logic [3:0]    inc_s0, inc_s1, inc_m0, inc_m1;

    assign tick     = presc == P_LAST;
    assign nonzero  = |{m1, m0, s1, s0};
    assign last_sec = {m1, m0, s1, s0} == 16'h0001;

    // one-second BCD decrement with borrow from seconds into minutes
    assign borrow_m = (s0 == 4'd0) && (s1 == 4'd0);
    assign dec_s0   = (s0 != 4'd0) ? s0 - 4'd1 : 4'd9;
    assign dec_s1   = (s0 != 4'd0) ? s1 : (s1 != 4'd0) ? s1 - 4'd1 : 4'd5;
    assign dec_m0   = !borrow_m ? m0 : (m0 != 4'd0) ? m0 - 4'd1 : 4'd9;
    assign dec_m1   = (borrow_m && m0 == 4'd0) ? m1 - 4'd1 : m1;

    // set-mode increments; seconds wrap at 59 without touching minutes
    assign inc_s0 = (s0 == 4'd9) ? 4'd0 : s0 + 4'd1;
    assign inc_s1 = (s0 != 4'd9) ? s1 : (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
    assign inc_m0 = (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
    assign inc_m1 = (m0 != 4'd9) ? m1 : (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;

    always_comb begin
        state_n = state;
        s0_n    = s0;
        s1_n    = s1;
        m0_n    = m0;
        m1_n    = m1;
        presc_n = presc;
        acnt_n  = acnt;
        case (state)
            S_IDLE: begin
                if (btnClear) begin
                    {m1_n, m0_n, s1_n, s0_n} = 16'h0000;
                end else if (btnStart) begin
                    if (nonzero) begin
                        state_n = S_RUN;
                        presc_n = '0;
                    end
                end else begin
                    if (btnMin) begin
                        m0_n = inc_m0;
                        m1_n = inc_m1;
                    end
                    if (btnSec) begin
                        s0_n = inc_s0;
                        s1_n = inc_s1;
                    end
                end
            end
            S_RUN: begin
                if (btnClear) begin
                    state_n = S_IDLE;
                    presc_n = '0;
                    {m1_n, m0_n, s1_n, s0_n} = 16'h0000;
                end else begin
                    presc_n = tick ? '0 : btnStart ? presc : presc + 1'b1;
                    if (btnStart) state_n = S_PAUSE;
                    if (tick) begin
                        {m1_n, m0_n, s1_n, s0_n} = {dec_m1, dec_m0, dec_s1, dec_s0};
                        if (last_sec) begin
                            state_n = S_ALARM;
                            presc_n = '0;
                            acnt_n  = '0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (btnClear) begin
                    state_n = S_IDLE;
                    presc_n = '0;
                    {m1_n, m0_n, s1_n, s0_n} = 16'h0000;
                end else if (btnStart) begin
                    state_n = S_RUN;
                end
            end
            S_ALARM: begin
                if (btnClear || btnStart) begin
                    state_n = S_IDLE;
                    presc_n = '0;
                    acnt_n  = '0;
                end else begin
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        acnt_n = acnt + 1'b1;
                        if (acnt == A_LAST) begin
                            state_n = S_IDLE;
                            acnt_n  = '0;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            s0    <= 4'd0;
            s1    <= 4'd0;
            m0    <= 4'd0;
            m1    <= 4'd0;
            presc <= '0;
            acnt  <= '0;
        end else begin
            state <= state_n;
            s0    <= s0_n;
            s1    <= s1_n;
            m0    <= m0_n;
            m1    <= m1_n;
            presc <= presc_n;
            acnt  <= acnt_n;
        end
    end

    assign v0      = s0;
    assign v1      = s1;
    assign v2      = m0;
    assign v3      = m1;
    assign v4      = {2'b00, state};
    assign v5      = 4'd0;
    assign v6      = 4'd0;
    assign v7      = 4'd0;
    assign alarm   = state == S_ALARM;
    assign running = state == S_RUN;
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl: directed and random button stimulus against a reference
// model that tracks the count as whole minutes/seconds and the state by number.
module tb_egg_timer_ctrl;
    localparam int TD = 4;
    localparam int AS = 2;

    logic clk = 0, rst = 0;
    logic btnStart = 0, btnClear = 0, btnMin = 0, btnSec = 0;
    logic [3:0] v0, v1, v2, v3, v4, v5, v6, v7;
    logic alarm, running;
    int errors = 0, checks = 0;
    int mm = 0, ss = 0, ms = 0, ph = 0, ae = 0;

    egg_timer_ctrl #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clk(clk), .rst(rst),
        .btnStart(btnStart), .btnClear(btnClear), .btnMin(btnMin), .btnSec(btnSec),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
        .alarm(alarm), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mm = 0; ss = 0; ms = 0; ph = 0; ae = 0;
    endtask

    // ms: 0 idle, 1 run, 2 pause, 3 alarm; ph = cycles into the current second
    task automatic model(input logic st, input logic cl, input logic mn, input logic sc);
        int t;
        bit tk;
        t = -1;
        tk = ph == TD - 1;
        case (ms)
            0: if (cl) begin mm = 0; ss = 0; end
               else if (st) begin if (mm * 60 + ss > 0) begin ms = 1; ph = 0; end end
               else begin
                   if (mn) mm = (mm + 1) % 100;
                   if (sc) ss = (ss + 1) % 60;
               end
            1: if (cl) begin ms = 0; mm = 0; ss = 0; end
               else begin
                   if (tk) begin
                       t = mm * 60 + ss - 1;
                       mm = t / 60; ss = t % 60; ph = 0;
                   end else if (!st) ph++;
                   if (st) ms = 2;
                   if (t == 0) begin ms = 3; ph = 0; ae = 0; end
               end
            2: if (cl) begin ms = 0; mm = 0; ss = 0; end
               else if (st) ms = 1;
            default: if (cl || st) begin ms = 0; ae = 0; end
               else if (tk) begin
                   ph = 0; ae++;
                   if (ae == AS) begin ms = 0; ae = 0; end
               end else ph++;
        endcase
    endtask

    task automatic check_all();
        logic [15:0] e;
        e = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        chk("count", {16'h0, v3, v2, v1, v0}, {16'h0, e});
        chk("state", {28'h0, v4}, ms);
        chk("alarm", {31'h0, alarm}, (ms == 3) ? 1 : 0);
        chk("running", {31'h0, running}, (ms == 1) ? 1 : 0);
        chk("blank", {20'h0, v7, v6, v5}, 0);
    endtask

    task automatic cyc(input logic st = 0, input logic cl = 0, input logic mn = 0, input logic sc = 0);
        btnStart = st; btnClear = cl; btnMin = mn; btnSec = sc;
        @(posedge clk);
        if (rst) mdl_reset(); else model(st, cl, mn, sc);
        #1;
        btnStart = 0; btnClear = 0; btnMin = 0; btnSec = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        int r;
        #2 rst = 1;
        #1 mdl_reset();
        check_all();
        @(posedge clk);
        #1 rst = 0;
        check_all();
        // set-mode loading
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        chk("load_0103", {16'h0, v3, v2, v1, v0}, 32'h0103);
        chk("load_idle", {28'h0, v4}, 0);
        // start on an empty count is ignored
        cyc(0, 1);
        cyc(1);
        chk("empty_start", {28'h0, v4, 3'b0, running}, 0);
        // full minute run into alarm and auto-return
        cyc(0, 0, 1, 0);
        cyc(1);
        chk("run_flag", {31'h0, running}, 1);
        idle(4);
        chk("first_dec", {16'h0, v3, v2, v1, v0}, 32'h0059);
        idle(59 * 4);
        chk("alarm_cnt", {16'h0, v3, v2, v1, v0}, 32'h0000);
        chk("alarm_st", {27'h0, alarm, v4}, 32'h13);
        idle(7);
        chk("alarm_hold", {31'h0, alarm}, 1);
        idle(1);
        chk("alarm_end", {27'h0, alarm, v4}, 0);
        // pause freezes the count; resume keeps the prescaler phase
        repeat (5) cyc(0, 0, 0, 1);
        cyc(1);
        idle(6);
        cyc(1);
        idle(20);
        chk("pause_st", {28'h0, v4}, 2);
        chk("pause_cnt", {16'h0, v3, v2, v1, v0}, 32'h0004);
        cyc(1);
        idle(1);
        chk("resume_wait", {16'h0, v3, v2, v1, v0}, 32'h0004);
        idle(1);
        chk("resume_dec", {16'h0, v3, v2, v1, v0}, 32'h0003);
        // wrap boundaries
        cyc(0, 1);
        repeat (100) cyc(0, 0, 1, 0);
        chk("min_wrap", {16'h0, v3, v2, v1, v0}, 32'h0000);
        cyc(0, 0, 1, 0);
        repeat (60) cyc(0, 0, 0, 1);
        chk("sec_wrap", {16'h0, v3, v2, v1, v0}, 32'h0100);
        // clear beats start in RUN
        cyc(1);
        idle(3);
        cyc(1, 1);
        chk("clr_start", {12'h0, v4, v3, v2, v1, v0}, 0);
        // asynchronous reset mid-run at 00:03
        repeat (5) cyc(0, 0, 0, 1);
        cyc(1);
        idle(8);
        chk("pre_rst", {16'h0, v3, v2, v1, v0}, 32'h0003);
        #2 rst = 1;
        #1 mdl_reset();
        chk("async_rst", {running, alarm, v7, v6, v5, v4, v3, v2, v1, v0}, 0);
        check_all();
        @(posedge clk);
        #1 rst = 0;
        idle(2);
        chk("post_rst", {28'h0, v4}, 0);
        // random button traffic
        repeat (3000) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                #2 rst = 1;
                #1 mdl_reset();
                check_all();
                @(posedge clk);
                #1 rst = 0;
                check_all();
            end else if (r < 12) cyc(1);
            else if (r < 15) cyc(0, 1);
            else if (r < 21) cyc(0, 0, 1, 0);
            else if (r < 29) cyc(0, 0, 0, 1);
            else if (r < 31) cyc(0, 0, 1, 1);
            else if (r < 32) cyc(1, 1);
            else cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
